// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store unit with a request/grant/rvalid memory port and timeout.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  output logic        resp_we,
  output logic [4:0]  resp_rd,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, RESP = 2'd3;
  localparam logic [15:0] last_cnt = 16'(TIMEOUT_CYCLES - 1);
  logic [1:0]  state, state_n;
  logic        live, store_q, err_q, accept, bad, expired, stalled;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic [15:0] cnt;
  logic [31:0] addr_q, wdata_q, rdata_q, lane, ext;
  logic [3:0]  be;
  assign req_ready = live && state == IDLE;
  assign accept = req_valid && req_ready;
  assign bad = req_funct3[1:0] == 2'b11 || (req_funct3[2] && (req_store || req_funct3[1])) ||
               (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
               (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
  assign expired = cnt == last_cnt;
  assign stalled = (state == REQ && !mem_gnt) || (state == WAIT && !mem_rvalid);
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? (bad ? RESP : REQ) : IDLE;
      REQ:     state_n = mem_gnt ? (store_q ? RESP : WAIT) : (expired ? RESP : REQ);
      WAIT:    state_n = (mem_rvalid || expired) ? RESP : WAIT;
      default: state_n = IDLE;
    endcase
  end
  assign be = f3_q[1] ? 4'hf : f3_q[0] ? (addr_q[1] ? 4'hc : 4'h3) : 4'b0001 << addr_q[1:0];
  assign lane = mem_rdata >> {addr_q[1:0], 3'b000};
  // funct3[2] marks the unsigned variants, which suppress sign extension
  assign ext = f3_q[1] ? lane :
               f3_q[0] ? {{16{!f3_q[2] && lane[15]}}, lane[15:0]} :
                         {{24{!f3_q[2] && lane[7]}}, lane[7:0]};
  always_ff @(posedge clk) begin
    if (!rstN) begin
      state   <= IDLE;
      live    <= 1'b0;
      cnt     <= '0;
      store_q <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= '0;
      rd_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      live  <= 1'b1;
      state <= state_n;
      cnt   <= (accept || (state == REQ && mem_gnt)) ? '0 : stalled ? cnt + 16'd1 : cnt;
      if (accept) begin
        store_q <= req_store;
        err_q   <= bad;
        f3_q    <= req_funct3;
        rd_q    <= req_rd;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (stalled && expired) err_q <= 1'b1;
      if (state == WAIT && mem_rvalid) rdata_q <= ext;
    end
  end
  assign mem_req   = state == REQ;
  assign mem_we    = mem_req && store_q;
  assign mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : '0;
  assign mem_be    = mem_req ? be : '0;
  assign mem_wdata = !mem_we ? '0 : f3_q[1] ? wdata_q : f3_q[0] ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
  assign resp_valid = state == RESP;
  assign resp_we    = resp_valid && !store_q && !err_q;
  assign resp_err   = resp_valid && err_q;
  assign resp_rd    = resp_we ? rd_q : '0;
  assign resp_rdata = resp_we ? rdata_q : '0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench for load_store_unit.
module tb_load_store_unit;
  logic        clk = 1'b0, rstN = 1'b0;
  logic        req_valid = 1'b0, req_store = 1'b0, mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = '0, req_wdata = '0, mem_rdata = '0;
  logic [4:0]  req_rd = '0;
  logic        req_ready, resp_valid, resp_we, resp_err, mem_req, mem_we;
  logic [4:0]  resp_rd;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  int errors = 0, checks = 0;
  logic [37:0] mv;
  logic [34:0] rv;
  assign mv = {mem_req, mem_we, mem_be, mem_addr};
  assign rv = {resp_valid, resp_we, resp_err, resp_rdata};

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rstN(rstN), .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .resp_valid(resp_valid), .resp_we(resp_we), .resp_rd(resp_rd), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic present(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_before_issue got=%b exp=1", req_ready); end
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
    step;
    req_valid = 1'b0; req_store = ~st; req_funct3 = 3'b111; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0; req_rd = 5'd31;
  endtask

  task automatic test_reset;
    step;
    step;
    checks++;
    if ({req_ready, mv, rv} !== '0) begin errors++; $display("FAIL reset_outputs got=%0h exp=0", {req_ready, mv, rv}); end
    rstN = 1'b1;
    step;
    checks++;
    if (req_ready !== 1'b1 || rv !== '0) begin errors++; $display("FAIL reset_release got ready=%b rv=%0h exp ready=1 rv=0", req_ready, rv); end
  endtask

  task automatic test_loads;
    logic [2:0]  f3s [6] = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
    logic [31:0] adr [6] = '{32'h100, 32'h203, 32'h203, 32'h202, 32'h202, 32'h201};
    logic [31:0] dat [6] = '{32'hDEADBEEF, 32'h80112233, 32'h80112233, 32'h80112233, 32'h80112233, 32'h80112233};
    logic [31:0] exp [6] = '{32'hDEADBEEF, 32'hFFFFFF80, 32'h00000080, 32'hFFFF8011, 32'h00008011, 32'h00000022};
    logic [3:0]  bes [6] = '{4'hf, 4'h8, 4'h8, 4'hc, 4'hc, 4'h2};
    logic [31:0] wad [6] = '{32'h100, 32'h200, 32'h200, 32'h200, 32'h200, 32'h200};
    for (int i = 0; i < 6; i++) begin
      present(1'b0, f3s[i], adr[i], 32'h0, 5'(i + 1));
      checks++;
      if (mv !== {1'b1, 1'b0, bes[i], wad[i]}) begin errors++; $display("FAIL load%0d_mem got=%0h exp=%0h", i, mv, {1'b1, 1'b0, bes[i], wad[i]}); end
      mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h5A5A5A5A;
      step;
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = dat[i];
      checks++;
      if (mv !== '0 || rv !== '0) begin errors++; $display("FAIL load%0d_wait got mv=%0h rv=%0h exp 0", i, mv, rv); end
      step;
      mem_rvalid = 1'b0;
      checks++;
      if ({rv, resp_rd} !== {1'b1, 1'b1, 1'b0, exp[i], 5'(i + 1)}) begin
        errors++; $display("FAIL load%0d_resp got=%0h exp=%0h", i, {rv, resp_rd}, {1'b1, 1'b1, 1'b0, exp[i], 5'(i + 1)});
      end
      step;
      checks++;
      if (rv !== '0) begin errors++; $display("FAIL load%0d_pulse got=%0h exp=0", i, rv); end
    end
  endtask

  task automatic test_stores;
    logic [2:0]  f3s [3] = '{3'b001, 3'b000, 3'b010};
    logic [31:0] adr [3] = '{32'h2A2, 32'h101, 32'h104};
    logic [31:0] wd  [3] = '{32'h1234ABCD, 32'h00000055, 32'hCAFEF00D};
    logic [31:0] ewd [3] = '{32'hABCDABCD, 32'h55555555, 32'hCAFEF00D};
    logic [3:0]  bes [3] = '{4'hc, 4'h2, 4'hf};
    logic [31:0] wad [3] = '{32'h2A0, 32'h100, 32'h104};
    int waits [3] = '{3, 0, 1};
    for (int i = 0; i < 3; i++) begin
      present(1'b1, f3s[i], adr[i], wd[i], 5'd3);
      for (int w = 0; w <= waits[i]; w++) begin
        checks++;
        if ({mv, mem_wdata} !== {1'b1, 1'b1, bes[i], wad[i], ewd[i]}) begin
          errors++; $display("FAIL store%0d_mem_c%0d got=%0h exp=%0h", i, w, {mv, mem_wdata}, {1'b1, 1'b1, bes[i], wad[i], ewd[i]});
        end
        mem_gnt = (w == waits[i]);
        step;
      end
      mem_gnt = 1'b0;
      checks++;
      if (mv !== '0 || rv !== {1'b1, 1'b0, 1'b0, 32'h0}) begin errors++; $display("FAIL store%0d_resp got mv=%0h rv=%0h exp mv=0 rv=400000000", i, mv, rv); end
      step;
      checks++;
      if (rv !== '0) begin errors++; $display("FAIL store%0d_pulse got=%0h exp=0", i, rv); end
    end
  endtask

  task automatic test_errors;
    logic       sts [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0] f3s [4] = '{3'b010, 3'b011, 3'b100, 3'b001};
    logic [31:0] adr [4] = '{32'h102, 32'h100, 32'h100, 32'h201};
    for (int i = 0; i < 4; i++) begin
      present(sts[i], f3s[i], adr[i], 32'hFFFFFFFF, 5'd4);
      checks++;
      if (mv !== '0 || rv !== {1'b1, 1'b0, 1'b1, 32'h0}) begin errors++; $display("FAIL err%0d_resp got mv=%0h rv=%0h exp mv=0 rv=500000000", i, mv, rv); end
      step;
      checks++;
      if (rv !== '0 || req_ready !== 1'b1) begin errors++; $display("FAIL err%0d_idle got rv=%0h ready=%b exp rv=0 ready=1", i, rv, req_ready); end
    end
  endtask

  task automatic test_timeout;
    present(1'b0, 3'b010, 32'h300, 32'h0, 5'd6);
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (mv !== {1'b1, 1'b0, 4'hf, 32'h300} || rv !== '0) begin errors++; $display("FAIL to_req_c%0d got mv=%0h rv=%0h", c, mv, rv); end
      step;
    end
    checks++;
    if (mv !== '0 || rv !== {1'b1, 1'b0, 1'b1, 32'h0}) begin errors++; $display("FAIL to_req_resp got mv=%0h rv=%0h exp mv=0 rv=500000000", mv, rv); end
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    step;
    mem_rvalid = 1'b0;
    checks++;
    if (rv !== '0 || req_ready !== 1'b1) begin errors++; $display("FAIL to_late_rvalid got rv=%0h ready=%b exp rv=0 ready=1", rv, req_ready); end
    present(1'b0, 3'b010, 32'h304, 32'h0, 5'd7);
    mem_gnt = 1'b1;
    step;
    mem_gnt = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      checks++;
      if (rv !== '0 || mv !== '0) begin errors++; $display("FAIL to_wait_c%0d got rv=%0h mv=%0h exp 0", c, rv, mv); end
      step;
    end
    checks++;
    if (rv !== {1'b1, 1'b0, 1'b1, 32'h0}) begin errors++; $display("FAIL to_wait_resp got=%0h exp=500000000", rv); end
    step;
  endtask

  task automatic test_reset_mid;
    present(1'b0, 3'b010, 32'h400, 32'h0, 5'd9);
    mem_gnt = 1'b1;
    step;
    mem_gnt = 1'b0;
    rstN = 1'b0;
    step;
    rstN = 1'b1;
    checks++;
    if (req_ready !== 1'b0 || mv !== '0 || rv !== '0) begin errors++; $display("FAIL mid_reset got ready=%b mv=%0h rv=%0h exp all 0", req_ready, mv, rv); end
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
    step;
    mem_rvalid = 1'b0;
    checks++;
    if (rv !== '0 || req_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_after got rv=%0h ready=%b exp rv=0 ready=1", rv, req_ready); end
    present(1'b0, 3'b010, 32'h404, 32'h0, 5'd10);
    checks++;
    if (mv !== {1'b1, 1'b0, 4'hf, 32'h404}) begin errors++; $display("FAIL mid_next_mem got=%0h exp=%0h", mv, {1'b1, 1'b0, 4'hf, 32'h404}); end
    mem_gnt = 1'b1;
    step;
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0BADF00D;
    step;
    mem_rvalid = 1'b0;
    checks++;
    if ({rv, resp_rd} !== {1'b1, 1'b1, 1'b0, 32'h0BADF00D, 5'd10}) begin errors++; $display("FAIL mid_next_resp got=%0h exp=%0h", {rv, resp_rd}, {1'b1, 1'b1, 1'b0, 32'h0BADF00D, 5'd10}); end
    step;
  endtask

  initial begin
    test_reset;
    test_loads;
    test_stores;
    test_errors;
    test_timeout;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
